// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_n register and its burst sequencer.
// Shift mode and FSM state encodings.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_LSL = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_reg_ctrl.sv
// Burst sequencer: FSM, shift down-counter and latched mode.
// Drives shift/load strobes and the mode the datapath should use.
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic [CNT_W-1:0] Count,
  input  logic [1:0]       Mode,
  output logic             shift_en,
  output logic             load_sel,
  output shift_mode_t      act_mode,
  output logic             Busy,
  output logic             Done
);

  shift_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shift_mode_t      mode_q, mode_d;

  // next-state, counter and strobe decode
  always_comb begin
    state_d  = ST_IDLE;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    shift_en = 1'b0;
    load_sel = 1'b0;
    if (state_q == ST_RUN) begin
      if (Load) begin
        load_sel = 1'b1;
        cnt_d    = '0;
      end else begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = ST_DONE;
        else
          state_d = ST_RUN;
      end
    end else begin
      if (Load) begin
        load_sel = 1'b1;
      end else if (Start) begin
        mode_d = shift_mode_t'(Mode);
        cnt_d  = Count;
        if (Count != '0)
          state_d = ST_RUN;
        else
          state_d = ST_DONE;
      end else if (Shift_En) begin
        shift_en = 1'b1;
      end
    end
  end

  // state, counter and mode latch registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= SH_LSR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign act_mode = (state_q == ST_RUN) ?
                    mode_q : shift_mode_t'(Mode);
  assign Busy     = (state_q == ST_RUN);
  assign Done     = (state_q == ST_DONE);

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised load/shift register with burst sequencer.
// SHIFT_REG_ROTATE_EN enables rotate-right for mode 11.
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Busy,
  output logic             Done
);

  logic             shift_en;
  logic             load_sel;
  shift_mode_t      act_mode;
  logic [WIDTH-1:0] shifted;

  shift_reg_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (Load),
    .Start    (Start),
    .Shift_En (Shift_En),
    .Count    (Count),
    .Mode     (Mode),
    .shift_en (shift_en),
    .load_sel (load_sel),
    .act_mode (act_mode),
    .Busy     (Busy),
    .Done     (Done)
  );

  // one-step shift result for the active mode
  always_comb begin
    shifted = Data_Out;
    unique case (act_mode)
      SH_LSR: shifted = {Shift_In, Data_Out[WIDTH-1:1]};
      SH_LSL: shifted = {Data_Out[WIDTH-2:0], Shift_In};
      SH_ASR: shifted = {Data_Out[WIDTH-1],
                         Data_Out[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
      SH_ROR: shifted = {Data_Out[0], Data_Out[WIDTH-1:1]};
`else
      SH_ROR: shifted = {Shift_In, Data_Out[WIDTH-1:1]};
`endif
    endcase
  end

  // datapath register: load wins over shift
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      Data_Out <= '0;
    else if (load_sel)
      Data_Out <= D;
    else if (shift_en)
      Data_Out <= shifted;
  end

  assign Shift_Out = (act_mode == SH_LSL) ?
                     Data_Out[WIDTH-1] : Data_Out[0];

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed checks for shift_reg_n at WIDTH=8 and WIDTH=16.
// Honours SHIFT_REG_ROTATE_EN for the mode-11 expectation.
module tb_shift_reg_n;

  logic        Clk = 1'b0;
  logic        Reset;

  logic        a_load, a_sh_en, a_start, a_sin;
  logic [7:0]  a_d;
  logic [3:0]  a_cnt;
  logic [1:0]  a_mode;
  logic        a_sout, a_busy, a_done;
  logic [7:0]  a_q;

  logic        b_load, b_sh_en, b_start, b_sin;
  logic [15:0] b_d;
  logic [4:0]  b_cnt;
  logic [1:0]  b_mode;
  logic        b_sout, b_busy, b_done;
  logic [15:0] b_q;

  int total = 0;
  int bad   = 0;
  logic [7:0] base;

  shift_reg_n #(.WIDTH(8)) u_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (a_load),
    .D         (a_d),
    .Shift_En  (a_sh_en),
    .Start     (a_start),
    .Count     (a_cnt),
    .Mode      (a_mode),
    .Shift_In  (a_sin),
    .Shift_Out (a_sout),
    .Data_Out  (a_q),
    .Busy      (a_busy),
    .Done      (a_done)
  );

  shift_reg_n #(.WIDTH(16)) u_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (b_load),
    .D         (b_d),
    .Shift_En  (b_sh_en),
    .Start     (b_start),
    .Count     (b_cnt),
    .Mode      (b_mode),
    .Shift_In  (b_sin),
    .Shift_Out (b_sout),
    .Data_Out  (b_q),
    .Busy      (b_busy),
    .Done      (b_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset   = 1'b0;
    a_load  = 0; a_sh_en = 0; a_start = 0; a_sin = 0;
    a_d     = '0; a_cnt = '0; a_mode = 2'b00;
    b_load  = 0; b_sh_en = 0; b_start = 0; b_sin = 0;
    b_d     = '0; b_cnt = '0; b_mode = 2'b00;
    #2;
    chk("rst_q",    a_q, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    step();
    Reset = 1'b1;

    // load then burst of 3 LSR with Shift_In=1
    a_load = 1; a_d = 8'hB4;
    step();
    a_load = 0;
    chk("ld_b4", a_q, 8'hB4);
    chk("sout_b4", a_sout, 0);
    a_start = 1; a_mode = 2'b00; a_cnt = 4'd3; a_sin = 1;
    step();
    a_start = 0;
    chk("b3_busy0", a_busy, 1);
    chk("b3_done0", a_done, 0);
    step();
    chk("b3_q1", a_q, 8'hDA);
    chk("b3_busy1", a_busy, 1);
    step();
    chk("b3_q2", a_q, 8'hED);
    chk("b3_busy2", a_busy, 1);
    chk("b3_done2", a_done, 0);
    step();
    chk("b3_q3", a_q, 8'hF6);
    chk("b3_busy3", a_busy, 0);
    chk("b3_done3", a_done, 1);
    step();
    chk("b3_done4", a_done, 0);

    // ASR burst; live Mode changed mid-burst must not matter
    a_load = 1; a_d = 8'h81;
    step();
    a_load = 0;
    a_start = 1; a_mode = 2'b10; a_cnt = 4'd2; a_sin = 0;
    step();
    a_start = 0; a_mode = 2'b01;
    step();
    chk("asr_q1", a_q, 8'hC0);
    chk("asr_sout", a_sout, 0);
    step();
    chk("asr_q2", a_q, 8'hE0);
    chk("asr_done", a_done, 1);
    step();

    // mode 11, one shift, Shift_In=0
    a_load = 1; a_d = 8'h81;
    step();
    a_load = 0;
    a_start = 1; a_mode = 2'b11; a_cnt = 4'd1; a_sin = 0;
    step();
    a_start = 0;
    step();
`ifdef SHIFT_REG_ROTATE_EN
    base = 8'hC0;
`else
    base = 8'h40;
`endif
    chk("m11_q", a_q, {24'd0, base});
    chk("m11_done", a_done, 1);
    // Count=0 accepted in the Done cycle
    a_start = 1; a_cnt = 4'd0;
    step();
    a_start = 0;
    chk("c0_done", a_done, 1);
    chk("c0_busy", a_busy, 0);
    chk("c0_q", a_q, {24'd0, base});
    step();
    chk("c0_done_end", a_done, 0);
    chk("c0_busy_end", a_busy, 0);

    // burst of 5 aborted by Load; Shift_En ignored in RUN
    a_start = 1; a_mode = 2'b00; a_cnt = 4'd5; a_sin = 0;
    step();
    a_start = 0; a_sh_en = 1;
    step();
    chk("ab_q1", a_q, {24'd0, base >> 1});
    step();
    chk("ab_q2", a_q, {24'd0, base >> 2});
    chk("ab_busy", a_busy, 1);
    a_sh_en = 0; a_load = 1; a_d = 8'h3C;
    step();
    a_load = 0;
    chk("ab_q", a_q, 8'h3C);
    chk("ab_busy_end", a_busy, 0);
    chk("ab_done", a_done, 0);
    step();
    chk("ab_done2", a_done, 0);
    chk("ab_hold", a_q, 8'h3C);

    // async reset mid-burst
    a_start = 1; a_cnt = 4'd4;
    step();
    a_start = 0;
    step();
    chk("mr_busy_pre", a_busy, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mr_q", a_q, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_done", a_done, 0);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mr_no_done", a_done, 0);
    end

    // WIDTH=16: 16 manual LSL shifts of 1
    b_mode = 2'b01; b_sin = 1; b_sh_en = 1;
    for (int i = 0; i < 16; i++) begin
      chk("w16_sout", b_sout, 0);
      step();
    end
    b_sh_en = 0;
    chk("w16_q", b_q, 16'hFFFF);
    chk("w16_sout_full", b_sout, 1);
    chk("w16_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
